// File: rtl/breadboard_io_pkg.sv
// Shared definitions for the breadboard computer's front-panel input conditioning.
package breadboard_io_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_PRESSED  = 2'd1,
    ST_HELD     = 2'd2
  } btn_state_e;

  // Qualification and long-press times at the front-panel clock rate.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000;
  localparam int DEFAULT_HOLD_CYCLES     = 500000;

endpackage

// File: rtl/input_sync.sv
// Two-flop synchroniser for asynchronous panel inputs; both stages reset to 0.
module input_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Metastability filter: first stage may go metastable, second stage is used.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_meta <= {WIDTH{1'b0}};
      r_sync <= {WIDTH{1'b0}};
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/button_debounce.sv
// Push-button conditioner: synchronise, debounce, and emit press/release/long-press events.
module button_debounce
  import breadboard_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 16,
  parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
  parameter int HOLD_W          = 24
) (
  input  logic clk,
  input  logic i_reset,
  input  logic i_button,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_held
);

  localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic              w_s;
  logic              w_accept;
  logic              w_rise;
  logic              w_fall;
  logic [CNT_W-1:0]  r_db_cnt;
  logic              r_level;
  btn_state_e        r_state;
  btn_state_e        w_state_next;
  logic [HOLD_W-1:0] r_hold;
  logic [HOLD_W-1:0] w_hold_next;
  logic              r_press;
  logic              r_release;
  logic              r_long;
  logic              r_held;
  logic              w_press_next;
  logic              w_release_next;
  logic              w_long_next;
  logic              w_held_next;

  input_sync #(.WIDTH(1)) u_sync (
    .clk     (clk),
    .i_reset (i_reset),
    .i_d     (i_button),
    .o_q     (w_s)
  );

  assign w_accept = (w_s != r_level) && (r_db_cnt == DB_LAST);
  assign w_rise   = w_accept && !r_level;
  assign w_fall   = w_accept && r_level;

  // Qualification counter: any agreement with the accepted level restarts it.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_db_cnt <= {CNT_W{1'b0}};
      r_level  <= 1'b0;
    end else if (w_s == r_level) begin
      r_db_cnt <= {CNT_W{1'b0}};
    end else if (w_accept) begin
      r_db_cnt <= {CNT_W{1'b0}};
      r_level  <= ~r_level;
    end else begin
      r_db_cnt <= r_db_cnt + CNT_W'(1);
    end
  end

  // Next-state and event decode; a fall on the hold-expiry edge wins over o_long.
  always_comb begin
    w_state_next   = r_state;
    w_hold_next    = r_hold;
    w_press_next   = 1'b0;
    w_release_next = 1'b0;
    w_long_next    = 1'b0;
    case (r_state)
      ST_RELEASED: begin
        if (w_rise) begin
          w_state_next = ST_PRESSED;
          w_hold_next  = {HOLD_W{1'b0}};
          w_press_next = 1'b1;
        end else begin
          w_state_next = ST_RELEASED;
        end
      end
      ST_PRESSED: begin
        if (w_fall) begin
          w_state_next   = ST_RELEASED;
          w_release_next = 1'b1;
        end else if (r_hold == HOLD_LAST) begin
          w_state_next = ST_HELD;
          w_long_next  = 1'b1;
        end else begin
          w_hold_next = r_hold + HOLD_W'(1);
        end
      end
      ST_HELD: begin
        if (w_fall) begin
          w_state_next   = ST_RELEASED;
          w_release_next = 1'b1;
        end else begin
          w_state_next = ST_HELD;
        end
      end
      default: begin
        w_state_next = ST_RELEASED;
        w_hold_next  = {HOLD_W{1'b0}};
      end
    endcase
    w_held_next = (w_state_next == ST_HELD);
  end

  // State, hold counter and registered event outputs.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= ST_RELEASED;
      r_hold    <= {HOLD_W{1'b0}};
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
      r_held    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_hold    <= w_hold_next;
      r_press   <= w_press_next;
      r_release <= w_release_next;
      r_long    <= w_long_next;
      r_held    <= w_held_next;
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_long    = r_long;
  assign o_held    = r_held;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEBOUNCE_CYCLES=4, HOLD_CYCLES=10.
module tb_button_debounce;

  logic clk;
  logic i_reset;
  logic i_button;
  logic o_level;
  logic o_press;
  logic o_release;
  logic o_long;
  logic o_held;
  logic [4:0] w_outs;

  int n_checks;
  int n_fail;

  button_debounce #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (16),
    .HOLD_CYCLES     (10),
    .HOLD_W          (24)
  ) dut (
    .clk       (clk),
    .i_reset   (i_reset),
    .i_button  (i_button),
    .o_level   (o_level),
    .o_press   (o_press),
    .o_release (o_release),
    .o_long    (o_long),
    .o_held    (o_held)
  );

  // Packed view: {level, press, release, long, held}
  assign w_outs = {o_level, o_press, o_release, o_long, o_held};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %b expected %b (level,press,release,long,held) at %0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_run(input string tag, input int n, input logic [4:0] exp);
    for (int i = 0; i < n; i++) begin
      tick();
      check_eq(tag, w_outs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    i_reset  = 1'b1;
    i_button = 1'b0;

    // Reset state
    #1 check_eq("reset_async", w_outs, 5'b00000);
    expect_run("reset_hold", 2, 5'b00000);
    i_reset = 1'b0;

    // Clean press: high before edge 1, accepted at edge 6, pulse gone at edge 7
    i_button = 1'b1;
    expect_run("press_wait", 5, 5'b00000);
    expect_run("press_edge6", 1, 5'b11000);
    expect_run("press_edge7", 1, 5'b10000);

    // Long press: o_long at press edge + 10 (edge 16)
    expect_run("long_wait", 8, 5'b10000);
    expect_run("long_pulse", 1, 5'b10011);
    expect_run("held_stays", 10, 5'b10001);

    // Release from HELD: low before edge 27, accepted at edge 32
    i_button = 1'b0;
    expect_run("rel_wait", 5, 5'b10001);
    expect_run("rel_pulse", 1, 5'b00100);
    expect_run("rel_after", 3, 5'b00000);

    // Bounce: 1,0,1,0 then stable 1 -> single press 10 edges after first bounce edge
    i_button = 1'b1; tick(); check_eq("bounce_b1", w_outs, 5'b00000);
    i_button = 1'b0; tick(); check_eq("bounce_b2", w_outs, 5'b00000);
    i_button = 1'b1; tick(); check_eq("bounce_b3", w_outs, 5'b00000);
    i_button = 1'b0; tick(); check_eq("bounce_b4", w_outs, 5'b00000);
    i_button = 1'b1;
    expect_run("bounce_wait", 5, 5'b00000);
    expect_run("bounce_press", 1, 5'b11000);
    expect_run("bounce_level", 1, 5'b10000);
    i_button = 1'b0;
    expect_run("bounce_rel_wait", 5, 5'b10000);
    expect_run("bounce_rel", 1, 5'b00100);
    expect_run("bounce_idle", 2, 5'b00000);

    // Collision: fall accepted on the hold-expiry edge (press edge + 10)
    i_button = 1'b1;
    expect_run("coll_wait", 5, 5'b00000);
    expect_run("coll_press", 1, 5'b11000);
    expect_run("coll_hold", 4, 5'b10000);
    i_button = 1'b0;
    expect_run("coll_pre", 5, 5'b10000);
    expect_run("coll_edge", 1, 5'b00100);
    expect_run("coll_no_long", 12, 5'b00000);

    // Async reset while in HELD with button still pressed
    i_button = 1'b1;
    expect_run("rst_wait", 5, 5'b00000);
    expect_run("rst_press", 1, 5'b11000);
    expect_run("rst_pressed", 9, 5'b10000);
    expect_run("rst_long", 1, 5'b10011);
    expect_run("rst_held", 2, 5'b10001);
    i_reset = 1'b1;
    #1 check_eq("rst_immediate", w_outs, 5'b00000);
    expect_run("rst_active", 2, 5'b00000);
    i_reset = 1'b0;
    expect_run("rst_requal", 5, 5'b00000);
    expect_run("rst_repress", 1, 5'b11000);
    expect_run("rst_level", 1, 5'b10000);
    i_button = 1'b0;
    expect_run("rst_rel_wait", 5, 5'b10000);
    expect_run("rst_rel", 1, 5'b00100);
    expect_run("rst_idle", 2, 5'b00000);

    // Short glitch: two cycles high never qualifies
    i_button = 1'b1;
    tick(); check_eq("glitch_1", w_outs, 5'b00000);
    tick(); check_eq("glitch_2", w_outs, 5'b00000);
    i_button = 1'b0;
    expect_run("glitch_quiet", 20, 5'b00000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
# button_debounce

Conditions one mechanical push-button input for the breadboard computer's front panel, the input-side counterpart to the LED blink driver. It synchronises the raw asynchronous button level into `clk`, rejects contact bounce with a qualification counter, and produces a clean level plus single-cycle press, release and long-press pulses. Downstream consumers include the single-step clock control and the manual reset/mode keys.

## Interface
- `DEBOUNCE_CYCLES`, default 1000: consecutive synchronised cycles a new level must hold before it is accepted; legal range 1 to 2^CNT_W-1.
- `CNT_W`, default 16: width of the debounce counter.
- `HOLD_CYCLES`, default 500000: cycles after an accepted press before the long-press event fires; legal range 1 to 2^HOLD_W-1.
- `HOLD_W`, default 24: width of the hold counter.

Ports:
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `i_reset`  in  1  reset, asynchronous and active-high.
- `i_button`  in  1  raw button level, 1 = pressed; asynchronous to `clk`.
- `o_level`  out  1  debounced button level.
- `o_press`  out  1  one-cycle pulse on an accepted 0→1 transition.
- `o_release`  out  1  one-cycle pulse on an accepted 1→0 transition.
- `o_long`  out  1  one-cycle pulse when the press has been held for `HOLD_CYCLES`.
- `o_held`  out  1  high from `o_long` until the release is accepted.

## Operation
- **Synchroniser:** two flops, both reset to 0. The second flop's output is `s`.
- **Debounce counter:**
  - Cleared to 0 on any edge where `s == o_level`.
  - Otherwise increments by 1.
  - On an edge where `s != o_level` and the counter equals `DEBOUNCE_CYCLES-1`, the accepted level toggles and the counter clears.
  - Any bounce back to `o_level` before then restarts qualification from 0.
- **State machine** (states RELEASED, PRESSED, HELD):
  - RELEASED → PRESSED on an accepted rise. `o_press`=1 for that cycle; hold counter cleared.
  - PRESSED: the hold counter increments every cycle. When it equals `HOLD_CYCLES-1`, go to HELD with `o_long`=1 for one cycle and `o_held`=1.
  - PRESSED or HELD → RELEASED on an accepted fall. `o_release`=1 for one cycle; `o_held`=0 on the same edge.
- **Simultaneous events:** an accepted fall on the same edge as hold expiry → RELEASED, `o_release` pulses, `o_long` does not fire.
- **Counter wrap:** neither counter wraps. The debounce counter cannot exceed `DEBOUNCE_CYCLES-1`. The hold counter stops in HELD.
- **Reset:** asserting `i_reset` at any time, including mid-qualification or in HELD:
  - State → RELEASED; both counters, both sync flops and all outputs → 0.
  - A button held through reset release is reported as a fresh press after full qualification.
- **Invariant:** `o_press`, `o_release` and `o_long` are mutually exclusive in any cycle.

## Timing
- Reset values: `o_level`=0, `o_press`=0, `o_release`=0, `o_long`=0, `o_held`=0.
- Press latency: with `i_button` stable high before rising edge 1, `o_level` and `o_press` assert after edge 2+`DEBOUNCE_CYCLES`. Release latency is the same.
- `o_long` asserts exactly `HOLD_CYCLES` edges after the edge that asserted `o_press`.
- All outputs are registered. No combinational path from `i_button` to any output.
- Pulses are exactly one `clk` cycle wide.

## Structure
- Shared package `breadboard_io_pkg` holds:
  - the state encoding (RELEASED=2'd0, PRESSED=2'd1, HELD=2'd2);
  - default `DEBOUNCE_CYCLES` and `HOLD_CYCLES` constants for the front-panel clock rate.
- Sub-module `input_sync`: a two-flop synchroniser with async active-high reset. It is reused for other panel switches.
- Debounce counter, FSM and hold counter live in `button_debounce`.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `HOLD_CYCLES`=10.
- **Clean press:** `i_button` 0→1 before edge 1, held → `o_level` and `o_press` high after edge 6; `o_press` low after edge 7.
- **Bounce:** `i_button` toggles 1,0,1,0 on successive cycles, then stays 1 → no output change until 4 stable synchronised cycles, then exactly one `o_press`.
- **Long press:** held 20 cycles after `o_press` → `o_long` pulses 10 edges after `o_press`; `o_held` stays 1; release → `o_release` pulse and `o_held`=0 on the same edge.
- **Release-vs-hold collision:** release timed so the fall is accepted on the hold-expiry edge → `o_release`=1, `o_long` never asserts, state RELEASED.
- **Async reset mid-HELD with button held:** pulse `i_reset` between edges → all outputs 0 immediately; after release of reset, `o_press` reasserts 6 edges later.
- **Short glitch:** a 2-cycle high pulse on `i_button` → no output activity at all.
